collide_score: RTL
==================

Name: collide_score

Overview:
- Consumes the three pipe coordinate pairs from the pipe generator and the bird's position from the bird physics stage.
- Runs the game-state FSM (IDLE/PLAY/DEAD) and drives the `start` level back to the pipe generator.
- Detects bird–pipe and bird–boundary collisions once per frame tick.
- Keeps a 4-digit BCD score and best score for the display stage.

Parameters:
- PIPE_W, 12'd52: pipe column width in pixels; pipe occupies x in [pipe_x, pipe_x+PIPE_W).
- GAP_H, 12'd120: vertical gap height; gap occupies y in [pipe_y, pipe_y+GAP_H).
- BIRD_W, 12'd34: bird sprite width.
- BIRD_H, 12'd24: bird sprite height.
- SCR_H, 12'd480: ground line; a bird bottom edge at or beyond this is a collision.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick  in  1  one-cycle frame-update pulse (same pulse that advances pipes)
- btn  in  1  one-cycle debounced flap/start press
- bird_x  in  12  bird left edge
- bird_y  in  12  bird top edge
- pipe1_x, pipe1_y, pipe2_x, pipe2_y, pipe3_x, pipe3_y  in  12 each  pipe left edge / gap top
- start  out  1  high while in PLAY; gates pipe/bird motion
- game_over  out  1  high while in DEAD
- hit  out  1  one-cycle pulse on the collision that ends a game
- score  out  16  4 BCD digits of current score
- best  out  16  4 BCD digits of best score since reset

Behaviour:
- Reset: state=IDLE, start=0, game_over=0, hit=0, score=0, best=0, all passed flags=0, all prev_x registers=0.

FSM:
- IDLE: btn -> PLAY; score cleared to 0 on this transition.
- PLAY: registered collision on a tick -> DEAD.
- DEAD: btn -> IDLE. best is updated on entry to DEAD if score > best (BCD compare = unsigned compare of the 16-bit vector).
- A btn press in IDLE does not also count as a flap event; start asserts the cycle after btn.

Collision, evaluated only on cycles with tick=1 in PLAY:
- Per pipe i, x overlap: bird_x+BIRD_W > pipe_x AND bird_x < pipe_x+PIPE_W.
- Per pipe i, y outside gap: bird_y < pipe_y OR bird_y+BIRD_H > pipe_y+GAP_H.
- Collision = any pipe with (x overlap AND y outside gap), OR bird_y+BIRD_H >= SCR_H, OR bird_y == 0.
- All sums are computed at 13 bits; no wrap-around false negatives.
- Latency: inputs sampled on the tick cycle; state becomes DEAD and hit pulses on the next clock edge.
- start drops the same edge, so the pipe generator freezes one cycle after the tick.

Scoring, on tick in PLAY:
- Pipe i counts as passed when pipe_x+PIPE_W <= bird_x and passed_i=0. This sets passed_i and increments score by 1.
- Multiple pipes passing in the same tick add their count (0–3).
- passed_i clears when pipe_x > prev_x_i, i.e. the pipe has respawned at the right. prev_x_i updates every tick.
- Collision and pass on the same tick: collision wins and score is unchanged.
- BCD increment carries digit by digit and saturates at 16'h9999.

Other conditions:
- btn in PLAY is ignored by this block.
- tick outside PLAY has no effect.
- rst asserted mid-game forces the reset values on the next edge, including best=0.

Decomposition:
- Shared game package: PIPE_W, GAP_H, BIRD_W, BIRD_H, SCR_H defaults and the state encoding (IDLE=2'd0, PLAY=2'd1, DEAD=2'd2).
- Sub-module bcd_add4:
  - combinational 4-digit BCD add of a 2-bit increment, saturating at 9999;
  - one instance, with registers kept in collide_score.

Test Plan:
- Reset then btn: start=1 one cycle after btn; score=16'h0000, best=16'h0000, game_over=0.
- Gap pass (bird_x=200, bird_y=200; pipe1_y=180, pipe1_x stepping from 260 down to 147 over ticks, pipes 2/3 at x=900):
  - no hit during the whole sequence;
  - score becomes 16'h0001 on the tick where pipe1_x+52 <= 200;
  - no further increment while pipe1_x keeps decreasing.
- Respawn rescore: pipe1_x jumps from 147 to 640, then descends past again -> score=16'h0002.
- Pipe hit (bird_y=100, pipe1_y=180, pipe1_x=210) on a tick:
  - next edge: hit=1 for one cycle, game_over=1, start=0;
  - best=score.
- Ground hit and simultaneity:
  - bird_y=456 (456+24=480) -> DEAD.
  - A pass and a collision on the same tick -> DEAD with score unchanged.
- Saturation and reset:
  - preload score to 16'h9998 via two passes in one tick -> 16'h9999, not wrapping.
  - rst in PLAY -> IDLE, score=0, best=0 next edge.

Source files
------------

// File: rtl/collide_score_pkg.sv
// Shared game constants and state encoding for the collision/score stage.
package collide_score_pkg;

  localparam logic [11:0] PIPE_W_DFLT = 12'd52;
  localparam logic [11:0] GAP_H_DFLT  = 12'd120;
  localparam logic [11:0] BIRD_W_DFLT = 12'd34;
  localparam logic [11:0] BIRD_H_DFLT = 12'd24;
  localparam logic [11:0] SCR_H_DFLT  = 12'd480;

  localparam int NUM_PIPES = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_e;

  // Widen before adding so coordinate sums never wrap.
  function automatic logic [12:0] add13(input logic [11:0] a, input logic [11:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/collide_score_bcd_add4.sv
// Combinational 4-digit BCD add of a 0..3 increment, saturating at 9999.
module bcd_add4 (
  input  logic [15:0] a,
  input  logic [1:0]  inc,
  output logic [15:0] sum
);

  logic [3:0] carry;
  logic [4:0] digit;

  always_comb begin
    sum   = 16'h0000;
    carry = {2'b00, inc};
    digit = 5'd0;
    for (int i = 0; i < 4; i++) begin
      digit = {1'b0, a[4*i +: 4]} + {1'b0, carry};
      if (digit > 5'd9) begin
        sum[4*i +: 4] = 4'(digit - 5'd10);
        carry         = 4'd1;
      end else begin
        sum[4*i +: 4] = digit[3:0];
        carry         = 4'd0;
      end
    end
    // A carry out of the top digit means the true result exceeds 9999.
    if (carry != 4'd0) begin
      sum = 16'h9999;
    end
  end

endmodule

// File: rtl/collide_score.sv
// Game-state FSM, per-tick collision detection and BCD score/best keeping.
module collide_score
  import collide_score_pkg::*;
#(
  parameter logic [11:0] PIPE_W = PIPE_W_DFLT,
  parameter logic [11:0] GAP_H  = GAP_H_DFLT,
  parameter logic [11:0] BIRD_W = BIRD_W_DFLT,
  parameter logic [11:0] BIRD_H = BIRD_H_DFLT,
  parameter logic [11:0] SCR_H  = SCR_H_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn,
  input  logic [11:0] bird_x,
  input  logic [11:0] bird_y,
  input  logic [11:0] pipe1_x,
  input  logic [11:0] pipe1_y,
  input  logic [11:0] pipe2_x,
  input  logic [11:0] pipe2_y,
  input  logic [11:0] pipe3_x,
  input  logic [11:0] pipe3_y,
  output logic        start,
  output logic        game_over,
  output logic        hit,
  output logic [15:0] score,
  output logic [15:0] best
);

  game_state_e state, state_next;

  logic [11:0] px [NUM_PIPES];
  logic [11:0] py [NUM_PIPES];
  logic [11:0] prev_x [NUM_PIPES];
  logic [NUM_PIPES-1:0] passed, passed_next, pass_now, pipe_hit;

  logic [12:0] bird_right, bird_bot;
  logic [12:0] pipe_end, gap_end;
  logic        x_ovl, y_out, respawn, eff_passed;
  logic        collide, play_tick;
  logic [1:0]  inc;
  logic [15:0] score_inc;

  assign px[0] = pipe1_x;
  assign px[1] = pipe2_x;
  assign px[2] = pipe3_x;
  assign py[0] = pipe1_y;
  assign py[1] = pipe2_y;
  assign py[2] = pipe3_y;

  assign bird_right = add13(bird_x, BIRD_W);
  assign bird_bot   = add13(bird_y, BIRD_H);

  always_comb begin
    pipe_hit    = '0;
    pass_now    = '0;
    passed_next = '0;
    pipe_end    = 13'd0;
    gap_end     = 13'd0;
    x_ovl       = 1'b0;
    y_out       = 1'b0;
    respawn     = 1'b0;
    eff_passed  = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_end    = add13(px[i], PIPE_W);
      gap_end     = add13(py[i], GAP_H);
      x_ovl       = (bird_right > {1'b0, px[i]}) && ({1'b0, bird_x} < pipe_end);
      y_out       = (bird_y < py[i]) || (bird_bot > gap_end);
      pipe_hit[i] = x_ovl && y_out;
      // A pipe moving right relative to last tick has respawned; re-arm it.
      respawn     = px[i] > prev_x[i];
      eff_passed  = passed[i] && !respawn;
      pass_now[i] = (pipe_end <= {1'b0, bird_x}) && !eff_passed;
      passed_next[i] = eff_passed || pass_now[i];
    end
  end

  assign collide = (|pipe_hit) || (bird_bot >= {1'b0, SCR_H}) || (bird_y == 12'd0);
  assign inc     = {1'b0, pass_now[0]} + {1'b0, pass_now[1]} + {1'b0, pass_now[2]};

  bcd_add4 u_bcd_add4 (
    .a   (score),
    .inc (inc),
    .sum (score_inc)
  );

  assign play_tick = (state == PLAY) && tick;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (btn) state_next = PLAY;
      PLAY:    if (tick && collide) state_next = DEAD;
      DEAD:    if (btn) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      hit    <= 1'b0;
      score  <= 16'h0000;
      best   <= 16'h0000;
      passed <= '0;
      for (int i = 0; i < NUM_PIPES; i++) prev_x[i] <= 12'd0;
    end else begin
      state <= state_next;
      hit   <= play_tick && collide;
      // New game starts with no pipe credited, whatever the last game left behind.
      if ((state == IDLE) && btn) begin
        score  <= 16'h0000;
        passed <= '0;
      end
      if (play_tick) begin
        for (int i = 0; i < NUM_PIPES; i++) prev_x[i] <= px[i];
        if (!collide) begin
          passed <= passed_next;
          score  <= score_inc;
        end else if (score > best) begin
          best <= score;
        end
      end
    end
  end

  assign start     = (state == PLAY);
  assign game_over = (state == DEAD);

endmodule
